// File: rtl/activation_output_packer_if.sv
// Output word stream of the activation packer: FWFT head plus valid/ready.
// master drives the word, slave drives out_ready.
interface activation_output_packer_if #(
    parameter int WORD_BYTES = 4
);
    logic [8*WORD_BYTES-1:0] out_data;
    logic [WORD_BYTES-1:0]   out_keep;
    logic                    out_last;
    logic                    out_valid;
    logic                    out_ready;

    modport master (
        output out_data,
        output out_keep,
        output out_last,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_keep,
        input  out_last,
        input  out_valid,
        output out_ready
    );
endinterface

// File: rtl/activation_output_packer.sv
// Packs INT8 activation results into words and queues them in a FWFT FIFO.
// Optional ACT_PACK_STATS_EN adds saturation/zero byte counters.
module activation_output_packer #(
    parameter int WORD_BYTES = 4,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          clear,
    input  logic [7:0]                    in_data,
    input  logic                          in_valid,
    input  logic                          flush,
    activation_output_packer_if.master    o_str,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow,
    output logic                          busy
`ifdef ACT_PACK_STATS_EN
    ,
    output logic [15:0]                   sat_count,
    output logic [15:0]                   zero_count
`endif
);
    localparam int CW = $clog2(WORD_BYTES);
    localparam int NW = CW + 1;
    localparam int LW = $clog2(FIFO_DEPTH);
    localparam int NL = LW + 1;
    localparam int WB = 8 * WORD_BYTES;
    localparam int EW = WB + WORD_BYTES + 1;

    typedef enum logic {S_EMPTY, S_FILL} state_t;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic [WB-1:0]   r_lanes;
    logic [EW-1:0]   r_mem [FIFO_DEPTH];
    logic [LW-1:0]   r_wp;
    logic [LW-1:0]   r_rp;
    logic [LW:0]     r_level;
    logic            r_ovf;

    logic [WB-1:0]         w_lanes;
    logic [NW-1:0]         w_n;
    logic [WORD_BYTES-1:0] w_keep;
    logic [EW-1:0]         w_word;
    logic [EW-1:0]         w_head;
    logic                  w_wrap;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_full;
    logic                  w_wr;
    logic                  w_valid;

    // Unwritten lanes stay zero because the packer clears them on every push.
    always_comb begin
        w_lanes = r_lanes;
        if (in_valid)
            w_lanes[{r_cnt, 3'b000} +: 8] = in_data;
    end

    assign w_n    = {1'b0, r_cnt} + {{CW{1'b0}}, in_valid};
    assign w_wrap = in_valid && (r_cnt == CW'(WORD_BYTES - 1));
    assign w_push = w_wrap || flush;

    always_comb begin
        w_keep = '0;
        for (int i = 0; i < WORD_BYTES; i++)
            w_keep[i] = w_wrap || (NW'(i) < w_n);
    end

    assign w_word  = {flush, w_keep, w_lanes};
    assign w_valid = (r_level != '0);
    assign w_full  = (r_level == NL'(FIFO_DEPTH));
    assign w_pop   = w_valid && o_str.out_ready;
    assign w_wr    = w_push && (!w_full || w_pop);
    assign w_head  = r_mem[r_rp];

    assign o_str.out_valid = w_valid;
    assign o_str.out_data  = w_valid ? w_head[WB-1:0] : '0;
    assign o_str.out_keep  = w_valid ? w_head[WB +: WORD_BYTES] : '0;
    assign o_str.out_last  = w_valid && w_head[EW-1];

    assign fifo_level = r_level;
    assign overflow   = r_ovf;
    assign busy       = (r_state == S_FILL) || w_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_EMPTY;
            r_cnt   <= '0;
            r_lanes <= '0;
        end else if (clear || w_push) begin
            r_state <= S_EMPTY;
            r_cnt   <= '0;
            r_lanes <= '0;
        end else if (in_valid) begin
            r_state <= S_FILL;
            r_cnt   <= r_cnt + CW'(1);
            r_lanes <= w_lanes;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr && !clear)
            r_mem[r_wp] <= w_word;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_level <= '0;
            r_ovf   <= 1'b0;
        end else if (clear) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_level <= '0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_wr)
                r_wp <= r_wp + LW'(1);
            if (w_pop)
                r_rp <= r_rp + LW'(1);
            if (w_push && w_full && !w_pop)
                r_ovf <= 1'b1;
            unique case ({w_wr, w_pop})
                2'b10:   r_level <= r_level + NL'(1);
                2'b01:   r_level <= r_level - NL'(1);
                default: r_level <= r_level;
            endcase
        end
    end

`ifdef ACT_PACK_STATS_EN
    logic [15:0] r_sat;
    logic [15:0] r_zero;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sat  <= '0;
            r_zero <= '0;
        end else if (clear) begin
            r_sat  <= '0;
            r_zero <= '0;
        end else if (in_valid) begin
            if ((in_data == 8'h7F || in_data == 8'h80) && r_sat != 16'hFFFF)
                r_sat <= r_sat + 16'd1;
            if (in_data == 8'h00 && r_zero != 16'hFFFF)
                r_zero <= r_zero + 16'd1;
        end
    end

    assign sat_count  = r_sat;
    assign zero_count = r_zero;
`endif
endmodule

// File: tb/tb_activation_output_packer.sv
// Directed bench for activation_output_packer with a word scoreboard.
// Build with ACT_PACK_STATS_EN defined to also cover the stats counters.
module tb_activation_output_packer;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       clear;
    logic [7:0] in_data;
    logic       in_valid;
    logic       flush;
    logic [3:0] fifo_level;
    logic       overflow;
    logic       busy;
`ifdef ACT_PACK_STATS_EN
    logic [15:0] sat_count;
    logic [15:0] zero_count;
`endif

    activation_output_packer_if #(.WORD_BYTES(4)) bus ();

    activation_output_packer #(
        .WORD_BYTES(4),
        .FIFO_DEPTH(8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (clear),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .flush      (flush),
        .o_str      (bus),
        .fifo_level (fifo_level),
        .overflow   (overflow),
        .busy       (busy)
`ifdef ACT_PACK_STATS_EN
        ,
        .sat_count  (sat_count),
        .zero_count (zero_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        last;
        logic [3:0]  keep;
        logic [31:0] data;
    } word_t;

    word_t sb[$];
    int n_checks = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input logic [7:0] b, input logic f);
        in_valid = 1'b1;
        in_data  = b;
        flush    = f;
        tick();
        in_valid = 1'b0;
        flush    = 1'b0;
    endtask

    task automatic exp_word(input logic l, input logic [3:0] k,
                            input logic [31:0] d);
        word_t w;
        w.last = l;
        w.keep = k;
        w.data = d;
        sb.push_back(w);
    endtask

    function automatic logic [31:0] mk(input int k);
        logic [31:0] w;
        for (int j = 0; j < 4; j++)
            w[8*j +: 8] = 8'(16 * k + j + 1);
        return w;
    endfunction

    task automatic feed_word(input int k);
        logic [31:0] w;
        w = mk(k);
        for (int j = 0; j < 4; j++)
            feed(w[8*j +: 8], 1'b0);
    endtask

    // A transfer happens on the next rising edge whenever valid&&ready here.
    always @(negedge clk) begin : mon
        word_t e;
        if (rst_n && !clear && bus.out_valid && bus.out_ready) begin
            chk("sb_nonempty", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("word", 64'({bus.out_last, bus.out_keep, bus.out_data}),
                    64'(e));
            end
        end
    end

    initial begin
        logic [31:0] w;
        rst_n         = 1'b0;
        clear         = 1'b0;
        in_data       = 8'h00;
        in_valid      = 1'b0;
        flush         = 1'b0;
        bus.out_ready = 1'b0;
        tick();
        tick();
        chk("rst_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_data", 64'(bus.out_data), 64'd0);
        chk("rst_keep_last", 64'({bus.out_keep, bus.out_last}), 64'd0);
        chk("rst_level", 64'(fifo_level), 64'd0);
        chk("rst_ovf_busy", 64'({overflow, busy}), 64'd0);
        rst_n = 1'b1;

        bus.out_ready = 1'b1;
        feed(8'h01, 1'b0);
        feed(8'h02, 1'b0);
        feed(8'h03, 1'b0);
        chk("fill_busy", 64'(busy), 64'd1);
        chk("fill_no_valid", 64'(bus.out_valid), 64'd0);
        exp_word(1'b0, 4'b1111, 32'h04030201);
        feed(8'h04, 1'b0);
        chk("word1_valid", 64'(bus.out_valid), 64'd1);
        chk("word1_level", 64'(fifo_level), 64'd1);
        tick();
        chk("word1_popped", 64'(fifo_level), 64'd0);

        feed(8'hAA, 1'b0);
        feed(8'hBB, 1'b0);
        exp_word(1'b1, 4'b0011, 32'h0000BBAA);
        in_valid = 1'b0;
        flush    = 1'b1;
        tick();
        flush    = 1'b0;
        chk("partial_last", 64'(bus.out_last), 64'd1);

        feed(8'h11, 1'b0);
        feed(8'h22, 1'b0);
        feed(8'h33, 1'b0);
        exp_word(1'b1, 4'b1111, 32'hCC332211);
        feed(8'hCC, 1'b1);

        exp_word(1'b1, 4'b0000, 32'h0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        repeat (3) tick();
        chk("idle_level", 64'(fifo_level), 64'd0);
        chk("idle_busy", 64'(busy), 64'd0);

        bus.out_ready = 1'b0;
        for (int k = 0; k < 9; k++) begin
            if (k < 8)
                exp_word(1'b0, 4'b1111, mk(k));
            feed_word(k);
        end
        chk("full_level", 64'(fifo_level), 64'd8);
        chk("full_ovf", 64'(overflow), 64'd1);
        chk("full_head", 64'(bus.out_data), 64'(mk(0)));
        tick();
        chk("hold_head", 64'({bus.out_valid, bus.out_data}), 64'({1'b1, mk(0)}));
        bus.out_ready = 1'b1;
        repeat (10) tick();
        chk("drain_level", 64'(fifo_level), 64'd0);
        chk("drain_sb", 64'(sb.size()), 64'd0);
        chk("ovf_sticky", 64'(overflow), 64'd1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("clear_ovf", 64'(overflow), 64'd0);

        bus.out_ready = 1'b0;
        for (int k = 0; k < 8; k++) begin
            exp_word(1'b0, 4'b1111, mk(k));
            feed_word(k);
        end
        chk("full2_level", 64'(fifo_level), 64'd8);
        w = mk(9);
        exp_word(1'b0, 4'b1111, w);
        feed(w[7:0], 1'b0);
        feed(w[15:8], 1'b0);
        feed(w[23:16], 1'b0);
        bus.out_ready = 1'b1;
        feed(w[31:24], 1'b0);
        chk("pushpop_level", 64'(fifo_level), 64'd8);
        chk("pushpop_ovf", 64'(overflow), 64'd0);
        repeat (12) tick();
        chk("drain2_level", 64'(fifo_level), 64'd0);

        feed(8'h91, 1'b0);
        feed(8'h92, 1'b0);
        in_valid = 1'b1;
        in_data  = 8'h93;
        clear    = 1'b1;
        tick();
        clear    = 1'b0;
        in_valid = 1'b0;
        chk("clear_busy", 64'(busy), 64'd0);

        bus.out_ready = 1'b0;
        feed_word(3);
        feed(8'hE1, 1'b0);
        feed(8'hE2, 1'b0);
        chk("pre_rst_level", 64'(fifo_level), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(bus.out_valid), 64'd0);
        chk("mid_rst_data", 64'(bus.out_data), 64'd0);
        chk("mid_rst_level", 64'(fifo_level), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        tick();
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        exp_word(1'b0, 4'b1111, 32'h88776655);
        feed(8'h55, 1'b0);
        feed(8'h66, 1'b0);
        feed(8'h77, 1'b0);
        feed(8'h88, 1'b0);
        repeat (3) tick();

`ifdef ACT_PACK_STATS_EN
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("stats_clear", 64'({sat_count, zero_count}), 64'd0);
        exp_word(1'b0, 4'b1111, 32'h0500807F);
        feed(8'h7F, 1'b0);
        feed(8'h80, 1'b0);
        feed(8'h00, 1'b0);
        feed(8'h05, 1'b0);
        chk("sat_count", 64'(sat_count), 64'd2);
        chk("zero_count", 64'(zero_count), 64'd1);
`endif

        repeat (12) tick();
        chk("final_sb", 64'(sb.size()), 64'd0);
        chk("final_busy", 64'(busy), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
